// File: rtl/dwidth_pkg.sv
// +---------------------------------------------------------------------------+
// | Module      : dwidth_pkg                                                  |
// | Description : Shared FSM encodings and byte-enable slice helper for the   |
// |               BRAM data-width upsizer.                                    |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
`default_nettype none

package dwidth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } upsizer_state_e;

  typedef enum logic {
    ISSUE   = 1'b0,
    CAPTURE = 1'b1
  } rd_phase_e;

  // Widest byte-enable vector the helper handles (512-bit wide words)
  localparam int unsigned MAX_BE_W = 64;

  // Returns byte-enable slice k (nbe bits each), right-aligned and zero-padded
  function automatic logic [MAX_BE_W-1:0] beat_slice_be(input logic [MAX_BE_W-1:0] be,
                                                        input int unsigned        k,
                                                        input int unsigned        nbe);
    logic [MAX_BE_W-1:0] mask;
    mask = {MAX_BE_W{1'b1}} >> (MAX_BE_W - nbe);
    return (be >> (k * nbe)) & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bram_dwidth_upsizer.sv
// +---------------------------------------------------------------------------+
// | Module      : bram_dwidth_upsizer                                         |
// | Description : Serialises wide read/write requests into RATIO narrow BRAM  |
// |               beats and gathers read beats into one wide response.        |
// |               BRAM_UPSIZER_RD_PIPELINE_EN overlaps read issue/capture.    |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
`default_nettype none

module bram_dwidth_upsizer
  import dwidth_pkg::*;
#(
  parameter int unsigned NARROW_WIDTH = 32,
  parameter int unsigned WIDE_WIDTH   = 128,
  parameter int unsigned RATIO        = WIDE_WIDTH / NARROW_WIDTH,
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned WADDR_W      = $clog2(DEPTH),
  parameter int unsigned NADDR_W      = WADDR_W + $clog2(RATIO)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_we_i,
  input  logic [WADDR_W-1:0]        req_addr_i,
  input  logic [WIDE_WIDTH-1:0]     req_wdata_i,
  input  logic [WIDE_WIDTH/8-1:0]   req_be_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [WIDE_WIDTH-1:0]     rsp_rdata_o,
  output logic                      mem_en_o,
  output logic                      mem_we_o,
  output logic [NADDR_W-1:0]        mem_addr_o,
  output logic [NARROW_WIDTH-1:0]   mem_wdata_o,
  output logic [NARROW_WIDTH/8-1:0] mem_be_o,
  input  logic [NARROW_WIDTH-1:0]   mem_rdata_i,
  output logic                      busy_o
);

  localparam int unsigned BEAT_W = $clog2(RATIO);
  localparam int unsigned NBE    = NARROW_WIDTH / 8;
  localparam int unsigned WBE    = WIDE_WIDTH / 8;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

  upsizer_state_e            r_state, w_state_nxt;
  logic [BEAT_W-1:0]         r_beat, w_beat_nxt;
  logic [WADDR_W-1:0]        r_addr;
  logic [WIDE_WIDTH-1:0]     r_wdata;
  logic [WIDE_WIDTH-1:0]     r_rdata;
  logic [WBE-1:0]            r_be;
  logic                      w_accept;
  logic                      w_capture;
  logic [BEAT_W-1:0]         w_cap_idx;
  logic [MAX_BE_W-1:0]       w_be_ext;
  logic [MAX_BE_W-1:0]       w_be_slice;
  logic                      w_be_any;

`ifdef BRAM_UPSIZER_RD_PIPELINE_EN
  logic                      r_pend, w_pend_nxt;
  logic                      r_issue_done, w_issue_done_nxt;
  logic [BEAT_W-1:0]         r_cap_idx;
`else
  rd_phase_e                 r_phase, w_phase_nxt;
`endif

  always_comb begin
    w_be_ext            = '0;
    w_be_ext[WBE-1:0]   = r_be;
    w_be_slice          = beat_slice_be(w_be_ext, 32'(r_beat), NBE);
    w_be_any            = |w_be_slice;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_cap_idx   = r_beat;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
`ifdef BRAM_UPSIZER_RD_PIPELINE_EN
    w_pend_nxt       = 1'b0;
    w_issue_done_nxt = r_issue_done;
`else
    w_phase_nxt      = r_phase;
`endif

    case (r_state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          w_accept    = 1'b1;
          w_beat_nxt  = '0;
          w_state_nxt = req_we_i ? WRITE : READ;
`ifdef BRAM_UPSIZER_RD_PIPELINE_EN
          w_issue_done_nxt = 1'b0;
`else
          w_phase_nxt      = ISSUE;
`endif
        end
      end

      WRITE: begin
        // All-zero enable slices still consume their beat slot
        if (w_be_any) begin
          mem_en_o    = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = {r_addr, r_beat};
          mem_wdata_o = r_wdata[32'(r_beat) * NARROW_WIDTH +: NARROW_WIDTH];
          mem_be_o    = w_be_slice[NBE-1:0];
        end
        if (r_beat == LAST_BEAT) begin
          w_beat_nxt  = '0;
          w_state_nxt = RESP;
        end else begin
          w_beat_nxt  = r_beat + 1'b1;
        end
      end

      READ: begin
`ifdef BRAM_UPSIZER_RD_PIPELINE_EN
        if (!r_issue_done) begin
          mem_en_o   = 1'b1;
          mem_addr_o = {r_addr, r_beat};
          w_pend_nxt = 1'b1;
          if (r_beat == LAST_BEAT) w_issue_done_nxt = 1'b1;
          else                     w_beat_nxt       = r_beat + 1'b1;
        end
        if (r_pend) begin
          w_capture = 1'b1;
          w_cap_idx = r_cap_idx;
        end
        // Drain cycle: last beat captured, nothing left to issue
        if (r_issue_done && r_pend) begin
          w_beat_nxt  = '0;
          w_state_nxt = RESP;
        end
`else
        if (r_phase == ISSUE) begin
          mem_en_o    = 1'b1;
          mem_addr_o  = {r_addr, r_beat};
          w_phase_nxt = CAPTURE;
        end else begin
          w_capture   = 1'b1;
          w_phase_nxt = ISSUE;
          if (r_beat == LAST_BEAT) begin
            w_beat_nxt  = '0;
            w_state_nxt = RESP;
          end else begin
            w_beat_nxt  = r_beat + 1'b1;
          end
        end
`endif
      end

      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) w_state_nxt = IDLE;
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_beat       <= '0;
`ifdef BRAM_UPSIZER_RD_PIPELINE_EN
      r_pend       <= 1'b0;
      r_issue_done <= 1'b0;
      r_cap_idx    <= '0;
`else
      r_phase      <= ISSUE;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_beat       <= w_beat_nxt;
`ifdef BRAM_UPSIZER_RD_PIPELINE_EN
      r_pend       <= w_pend_nxt;
      r_issue_done <= w_issue_done_nxt;
      r_cap_idx    <= r_beat;
`else
      r_phase      <= w_phase_nxt;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= req_addr_i;
        r_wdata <= req_wdata_i;
        r_be    <= req_be_i;
        r_rdata <= '0;
      end
      if (w_capture) begin
        r_rdata[32'(w_cap_idx) * NARROW_WIDTH +: NARROW_WIDTH] <= mem_rdata_i;
      end
    end
  end

  assign rsp_rdata_o = r_rdata;
  assign busy_o      = (r_state != IDLE);

endmodule

`default_nettype wire
